// File: rtl/notch_sweep_ctrl.sv
// notch_sweep_ctrl
//   Sweep sequencer for notch-filter characterisation. Steps the AC stimulus
//   source through N_POINTS frequency indices. At each point it waits
//   SETTLE_CYC cycles, then handshakes one gain measurement and keeps track of
//   the lowest gain seen (notch depth) and the index where it occurred.
//
//   Optional feature (macro NOTCH_SWEEP_DC_CAL_EN):
//     Before the sweep a DCCAL phase runs with the source disabled. It settles,
//     captures one measurement as dc_ofs, and every later capture becomes
//     meas_mag - dc_ofs, saturated to the signed MAG_W range.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start, abort      host control (abort wins over everything outside IDLE)
//   src_en, freq_idx  stimulus source enable / current sweep point
//   meas_req          measurement request, held until meas_ack
//   meas_ack,meas_mag measurement valid pulse and signed gain (1/256 dB LSB)
//   busy, done        sweep in progress / one-cycle completion pulse
//   min_mag, min_idx  notch depth and position
//
// All outputs are registered. They are decoded from the next state, so they
// line up with the state register without any input-to-output path.
module notch_sweep_ctrl #(
  parameter int N_POINTS   = 64,
  parameter int IDX_W      = 6,
  parameter int MAG_W      = 16,
  parameter int SETTLE_CYC = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             src_en,
  output logic [IDX_W-1:0] freq_idx,
  output logic             meas_req,
  input  logic             meas_ack,
  input  logic [MAG_W-1:0] meas_mag,
  output logic             busy,
  output logic             done,
  output logic [MAG_W-1:0] min_mag,
  output logic [IDX_W-1:0] min_idx
);

  localparam int CNT_W = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_POINTS - 1);
  localparam logic [MAG_W-1:0] MAG_MAX  = {1'b0, {(MAG_W-1){1'b1}}};
  localparam logic [MAG_W-1:0] MAG_MIN  = {1'b1, {(MAG_W-1){1'b0}}};

`ifdef NOTCH_SWEEP_DC_CAL_EN
  typedef enum logic [2:0] {
    S_IDLE, S_DCCAL, S_SETTLE, S_MEASURE, S_UPDATE, S_DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_MEASURE, S_UPDATE, S_DONE
  } state_t;
`endif

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [IDX_W-1:0] idx_nxt, min_idx_nxt;
  logic [MAG_W-1:0] cap, cap_nxt, min_mag_nxt;
  logic [MAG_W-1:0] corr;
  logic             req_nxt;

`ifdef NOTCH_SWEEP_DC_CAL_EN
  // dc_meas: DCCAL has finished its settle wait and is in its handshake.
  logic             dc_meas, dc_meas_nxt;
  logic [MAG_W-1:0] dc_ofs, dc_ofs_nxt;
  logic [MAG_W:0]   diff;

  // One guard bit is enough for a difference of two MAG_W signed values;
  // disagreement between the top two bits means the result left the range.
  always_comb begin
    diff = {meas_mag[MAG_W-1], meas_mag} - {dc_ofs[MAG_W-1], dc_ofs};
    if (diff[MAG_W] != diff[MAG_W-1]) corr = diff[MAG_W] ? MAG_MIN : MAG_MAX;
    else                              corr = diff[MAG_W-1:0];
  end
`else
  always_comb corr = meas_mag;
`endif

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    idx_nxt     = freq_idx;
    cap_nxt     = cap;
    min_mag_nxt = min_mag;
    min_idx_nxt = min_idx;
`ifdef NOTCH_SWEEP_DC_CAL_EN
    dc_meas_nxt = dc_meas;
    dc_ofs_nxt  = dc_ofs;
`endif
    if (abort && state != S_IDLE) begin
      // min_* keep the partial result; a pending UPDATE is dropped too.
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: if (start) begin
          idx_nxt     = '0;
          min_mag_nxt = MAG_MAX;
          min_idx_nxt = '0;
          cnt_nxt     = '0;
`ifdef NOTCH_SWEEP_DC_CAL_EN
          dc_meas_nxt = 1'b0;
          state_nxt   = S_DCCAL;
`else
          state_nxt   = S_SETTLE;
`endif
        end
`ifdef NOTCH_SWEEP_DC_CAL_EN
        S_DCCAL: begin
          if (!dc_meas) begin
            if (cnt == CNT_LAST) begin
              cnt_nxt     = '0;
              dc_meas_nxt = 1'b1;
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end else if (meas_ack) begin
            dc_ofs_nxt  = meas_mag;
            dc_meas_nxt = 1'b0;
            state_nxt   = S_SETTLE;
          end
        end
`endif
        S_SETTLE: begin
          if (cnt == CNT_LAST) begin
            cnt_nxt   = '0;
            state_nxt = S_MEASURE;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        S_MEASURE: if (meas_ack) begin
          cap_nxt   = corr;
          state_nxt = S_UPDATE;
        end
        S_UPDATE: begin
          // Strict compare keeps the earliest index on a tie.
          if ($signed(cap) < $signed(min_mag)) begin
            min_mag_nxt = cap;
            min_idx_nxt = freq_idx;
          end
          if (freq_idx == IDX_LAST) begin
            state_nxt = S_DONE;
          end else begin
            idx_nxt   = freq_idx + 1'b1;
            state_nxt = S_SETTLE;
          end
        end
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

`ifdef NOTCH_SWEEP_DC_CAL_EN
  always_comb req_nxt = (state_nxt == S_MEASURE) || (state_nxt == S_DCCAL && dc_meas_nxt);
`else
  always_comb req_nxt = (state_nxt == S_MEASURE);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      freq_idx <= '0;
      cap      <= '0;
      min_mag  <= MAG_MAX;
      min_idx  <= '0;
      src_en   <= 1'b0;
      meas_req <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef NOTCH_SWEEP_DC_CAL_EN
      dc_meas  <= 1'b0;
      dc_ofs   <= '0;
`endif
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      freq_idx <= idx_nxt;
      cap      <= cap_nxt;
      min_mag  <= min_mag_nxt;
      min_idx  <= min_idx_nxt;
      src_en   <= (state_nxt == S_SETTLE) || (state_nxt == S_MEASURE) ||
                  (state_nxt == S_UPDATE);
      meas_req <= req_nxt;
      busy     <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);
      done     <= (state_nxt == S_DONE);
`ifdef NOTCH_SWEEP_DC_CAL_EN
      dc_meas  <= dc_meas_nxt;
      dc_ofs   <= dc_ofs_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_notch_sweep_ctrl.sv
// Directed bench for notch_sweep_ctrl with N_POINTS=4, SETTLE_CYC=2.
module tb_notch_sweep_ctrl;
  localparam int NP = 4;
  localparam int IW = 6;
  localparam int MW = 16;
  localparam int SC = 2;
`ifdef NOTCH_SWEEP_DC_CAL_EN
  localparam int DC_HS = 1;
`else
  localparam int DC_HS = 0;
`endif

  logic          clk = 1'b0;
  logic          rst, start, abort, meas_ack;
  logic [MW-1:0] meas_mag;
  logic          src_en, meas_req, busy, done;
  logic [IW-1:0] freq_idx, min_idx;
  logic [MW-1:0] min_mag;

  int n_chk = 0;
  int n_err = 0;
  int n_done = 0;
  int n_hs = 0;

  notch_sweep_ctrl #(.N_POINTS(NP), .IDX_W(IW), .MAG_W(MW), .SETTLE_CYC(SC)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .src_en(src_en), .freq_idx(freq_idx), .meas_req(meas_req),
    .meas_ack(meas_ack), .meas_mag(meas_mag), .busy(busy), .done(done),
    .min_mag(min_mag), .min_idx(min_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done) n_done++;
    if (meas_req && meas_ack) n_hs++;
  end

  task automatic chk(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_req(input string tag);
    int k = 0;
    while (!meas_req && k < 100) begin tick(); k++; end
    chk({tag, "_req_seen"}, meas_req, 1);
  endtask

  // Waits for meas_req, checks the point index, then acks lat cycles later.
  task automatic serve(input string tag, input int mag, input int lat, input int exp_idx);
    wait_req(tag);
    chk({tag, "_idx"}, freq_idx, exp_idx);
    repeat (lat - 1) tick();
    meas_ack = 1'b1;
    meas_mag = MW'(mag);
    tick();
    meas_ack = 1'b0;
    meas_mag = '0;
    chk({tag, "_req_fall"}, meas_req, 0);
  endtask

  // Start pulse (or held start), first-point request timing, optional
  // spurious ack while settling, and the DC handshake when that feature exists.
  task automatic start_sweep(input string tag, input bit hold, input bit spur, input int dc);
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    chk({tag, "_busy_t1"}, busy, 1);
    chk({tag, "_req_t1"}, meas_req, 0);
    if (spur) begin meas_ack = 1'b1; meas_mag = MW'(-9999); end
    tick();
    meas_ack = 1'b0;
    meas_mag = '0;
    chk({tag, "_req_t2"}, meas_req, 0);
    tick();
    chk({tag, "_req_t3"}, meas_req, 1);
`ifdef NOTCH_SWEEP_DC_CAL_EN
    chk({tag, "_dc_srcoff"}, src_en, 0);
    serve({tag, "_dc"}, dc, 1, 0);
`else
    chk({tag, "_src_t3"}, src_en, 1);
    if (dc != 0) chk({tag, "_dc_unused"}, 0, 1);
`endif
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!done && k < 100) begin tick(); k++; end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_at_done"}, busy, 0);
    chk({tag, "_src_at_done"}, src_en, 0);
  endtask

  task automatic sweep4(input string tag, input int m0, input int m1, input int m2,
                        input int m3, input int dc, input int exp_min, input int exp_idx);
    int d0 = n_done;
    int h0 = n_hs;
    start_sweep(tag, 1'b0, 1'b0, dc);
    serve({tag, "_p0"}, m0, 3, 0);
    serve({tag, "_p1"}, m1, 3, 1);
    serve({tag, "_p2"}, m2, 3, 2);
    serve({tag, "_p3"}, m3, 3, 3);
    wait_done(tag);
    tick();
    chk({tag, "_done_once"}, n_done - d0, 1);
    chk({tag, "_handshakes"}, n_hs - h0, 4 + DC_HS);
    chk({tag, "_min_mag"}, $signed(min_mag), exp_min);
    chk({tag, "_min_idx"}, min_idx, exp_idx);
  endtask

  initial begin
    int req_seen = 0;
    int d0, h0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; meas_ack = 1'b0; meas_mag = '0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset / idle
    repeat (10) begin tick(); if (meas_req) req_seen++; end
    chk("rst_req_never", req_seen, 0);
    chk("rst_src_en", src_en, 0);
    chk("rst_freq_idx", freq_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_min_mag", $signed(min_mag), 32767);
    chk("rst_min_idx", min_idx, 0);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("idle_abort_busy", busy, 0);

    // Basic sweep with a tie at the minimum: earliest index wins
    sweep4("sw", -100, -2560, -2560, -50, 0, -2560, 1);
    chk("sw_done_low", done, 0);

    // Abort during the MEASURE of point 2
    d0 = n_done;
    start_sweep("ab", 1'b0, 1'b0, 0);
    chk("ab_min_cleared", $signed(min_mag), 32767);
    serve("ab_p0", -300, 3, 0);
    serve("ab_p1", -400, 3, 1);
    wait_req("ab_p2");
    abort = 1'b1; tick(); abort = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_src_en", src_en, 0);
    chk("ab_req", meas_req, 0);
    repeat (5) tick();
    chk("ab_no_done", n_done - d0, 0);
    chk("ab_min_mag", $signed(min_mag), -400);
    chk("ab_min_idx", min_idx, 1);

    // start held high throughout, spurious ack while settling
    d0 = n_done; h0 = n_hs;
    start_sweep("hs", 1'b1, 1'b1, 0);
    serve("hs_p0", 10, 2, 0);
    serve("hs_p1", 20, 1, 1);
    serve("hs_p2", 5, 4, 2);
    serve("hs_p3", 30, 2, 3);
    wait_done("hs");
    chk("hs_handshakes", n_hs - h0, 4 + DC_HS);
    chk("hs_min_mag", $signed(min_mag), 5);
    chk("hs_min_idx", min_idx, 2);
    tick();
    chk("hs_idle_busy", busy, 0);
    tick();
    chk("hs_restart_busy", busy, 1);
    chk("hs_restart_idx", freq_idx, 0);
    chk("hs_done_once", n_done - d0, 1);
    start = 1'b0;
    abort = 1'b1; tick(); abort = 1'b0;
    chk("hs_abort_busy", busy, 0);

`ifdef NOTCH_SWEEP_DC_CAL_EN
    // Offset correction with saturation at the negative rail
    sweep4("dcs", -32768, 1000, 1000, 1000, 512, -32768, 0);
    sweep4("dcc", 1000, 2000, 3000, 4000, 512, 488, 0);
`endif

    // Reset mid-sweep at point 3, then a fresh sweep
    start_sweep("rs", 1'b0, 1'b0, 0);
    serve("rs_p0", 5, 3, 0);
    serve("rs_p1", 6, 3, 1);
    serve("rs_p2", 7, 3, 2);
    wait_req("rs_p3");
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rs_busy", busy, 0);
    chk("rs_src_en", src_en, 0);
    chk("rs_req", meas_req, 0);
    chk("rs_idx", freq_idx, 0);
    chk("rs_min_mag", $signed(min_mag), 32767);
    chk("rs_min_idx", min_idx, 0);
    sweep4("rs2", 40, 30, 20, 10, 0, 10, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/notch_sweep_ctrl.md
# notch_sweep_ctrl

Sequencer for the notch-filter characterisation path: steps the AC stimulus source through a frequency sweep, waits for the filter to settle at each point, handshakes a gain measurement (dB(Out/In)) from the measurement unit and tracks the notch minimum. It sits between the stimulus source (frequency index and enable) and the gain-measurement unit, and reports the notch depth and position to the host.

## Interface
Parameters:
- N_POINTS, 64: sweep points, index 0..N_POINTS-1.
- IDX_W, 6: width of frequency index; N_POINTS ≤ 2^IDX_W.
- MAG_W, 16: signed gain code width, in 1/256 dB LSB.
- SETTLE_CYC, 16: settle cycles per point; ≥1.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin sweep; sampled only in IDLE.
- abort  in  1  terminate sweep; wins over every other event.
- src_en  out  1  enable AC stimulus source.
- freq_idx  out  IDX_W  current sweep point to stimulus source.
- meas_req  out  1  request gain measurement.
- meas_ack  in  1  measurement valid; one-cycle pulse.
- meas_mag  in  MAG_W  signed gain, valid with meas_ack.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse on sweep completion.
- min_mag  out  MAG_W  lowest gain seen (notch depth).
- min_idx  out  IDX_W  index of min_mag.

## Operation
- States: IDLE, DCCAL (macro only), SETTLE, MEASURE, UPDATE, DONE.
- IDLE: busy=0. start=1 clears freq_idx to 0, loads min_mag=max positive (0x7FFF for MAG_W=16), clears min_idx, goes to SETTLE, or to DCCAL when the macro is set.
- SETTLE: src_en=1. Counts SETTLE_CYC cycles, then goes to MEASURE.
- MEASURE: meas_req=1 and held until meas_ack. On the ack cycle, meas_mag is captured (offset-corrected when the macro is set) and the FSM goes to UPDATE. A meas_ack outside MEASURE is ignored.
- UPDATE: one cycle. If the captured value is strictly less than min_mag, min_mag and min_idx are updated; on a tie the earliest index is kept. If freq_idx==N_POINTS-1 the FSM goes to DONE, else freq_idx increments and the FSM returns to SETTLE. freq_idx never wraps.
- DONE: done=1 for one cycle, src_en=0, then IDLE. min_mag and min_idx hold until the next start.
- Signed compare on MAG_W bits. No arithmetic overflow exists outside the macro path.
- abort in any non-IDLE state: next state is IDLE with src_en=0 and meas_req=0. No done pulse. min_* keep their partial values. abort in IDLE has no effect.
- start while busy is ignored.

## Timing
- Reset values: src_en=0, freq_idx=0, meas_req=0, busy=0, done=0, min_mag=max positive, min_idx=0. State is IDLE.
- start at cycle t: busy=1 and src_en=1 from t+1.
- meas_req rises SETTLE_CYC cycles after SETTLE entry. It falls the cycle after meas_ack.
- Per point without the macro: SETTLE_CYC + (ack latency, ≥1) + 1 (UPDATE) cycles.
- done pulses the cycle after the last UPDATE. busy falls in the same cycle as the done pulse.
- Registered outputs only; no combinational path from inputs to outputs.

## Configuration
- NOTCH_SWEEP_DC_CAL_EN defined:
  - After start, DCCAL runs with src_en=0: SETTLE_CYC wait, then a meas_req/meas_ack handshake.
  - The captured value is stored as dc_ofs.
  - Every subsequent capture uses meas_mag − dc_ofs, saturated to the signed MAG_W range.
  - freq_idx stays 0 during DCCAL.
- Undefined: no DCCAL state, no dc_ofs register; raw meas_mag is used.

## Test plan
- Reset, then idle 10 cycles -> all outputs at reset values, meas_req never asserted.
- N_POINTS=4, SETTLE_CYC=2, ack 3 cycles after each req, mags {−100, −2560, −2560, −50} -> min_mag=−2560, min_idx=1, exactly one done pulse, 4 handshakes.
- abort asserted during the MEASURE of point 2 -> IDLE next cycle, src_en=0, no done pulse, min_* reflect points 0–1 only.
- start held high continuously, plus a spurious meas_ack during SETTLE -> the second start is ignored until IDLE, and the spurious ack is not captured.
- Macro set, DC capture=+512, point mags {−32768, 1000} -> corrected values saturate to −32768 and give 488; min_idx=0.
- rst asserted mid-sweep at point 3 -> reset values on the next cycle, and a new start sweeps again from freq_idx=0.
